// File: rtl/uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_pkt_ctrl
// Packet controller sitting behind uart_recv. It gates the receiver, detects
// byte completion on the falling edge of rec_busy, parses framed packets
// (HEADER, length, payload, XOR checksum), buffers the payload and streams a
// verified payload downstream over a valid/ready handshake.
//
// Ports
//   sys_clk, sys_rst_n      clock, async active-low reset
//   ctrl_en                 controller enable (low aborts a packet silently)
//   rec_dout, rec_busy      byte and busy flag from uart_recv
//   rec_en                  receiver enable to uart_recv
//   pkt_data/valid/last     payload stream, pkt_ready is the downstream accept
//   pkt_len                 length of the packet currently being streamed
//   err_len/err_chk/err_to  one-cycle error pulses (bad length, checksum,
//                           inter-byte timeout)
//
// state  | meaning
// IDLE   | hunting for HEADER, everything else discarded
// LEN    | waiting for the length byte
// DATA   | collecting payload bytes into the buffer, running XOR
// CHK    | waiting for the checksum byte
// SEND   | streaming buffered payload, receiver gated off
// ---------------------------------------------------------------------------
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       ctrl_en,
    input  logic [7:0] rec_dout,
    input  logic       rec_busy,
    output logic       rec_en,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic [7:0] pkt_len,
    output logic       err_len,
    output logic       err_chk,
    output logic       err_to
);

    localparam int IDX_W  = $clog2(MAX_LEN + 1);
    localparam int BUF_AW = $clog2(MAX_LEN);
    localparam int TO_W   = $clog2(TIMEOUT_CYC);

    // The timeout decision is taken in the cycle the counter would step onto
    // TIMEOUT_CYC-1, so err_to registers on the same edge the count would
    // have reached that value.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_SEND
    } state_t;

    state_t            r_state;
    logic              r_busy_d;
    logic [7:0]        r_len;
    logic [7:0]        r_chk;
    logic [IDX_W-1:0]  r_idx;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_rec_en;
    logic [7:0]        r_pkt_data;
    logic              r_pkt_valid;
    logic              r_pkt_last;
    logic [7:0]        r_pkt_len;
    logic              r_err_len;
    logic              r_err_chk;
    logic              r_err_to;
    logic [7:0]        r_buf [MAX_LEN];

    logic              w_byte_stb;
    logic              w_len_ok;
    logic              w_idx_final;
    logic              w_buf_we;
    logic [IDX_W-1:0]  w_idx_inc;

    assign w_byte_stb  = r_busy_d & ~rec_busy;
    assign w_len_ok    = (rec_dout != 8'd0) && (rec_dout <= 8'(MAX_LEN));
    assign w_idx_inc   = r_idx + IDX_W'(1);
    assign w_idx_final = (8'(r_idx) == (r_len - 8'd1));
    assign w_buf_we    = (r_state == S_DATA) && ctrl_en && w_byte_stb;

    // Payload storage carries no reset; contents are only read after being
    // written by the current packet.
    always_ff @(posedge sys_clk) begin
        if (w_buf_we) begin
            r_buf[r_idx[BUF_AW-1:0]] <= rec_dout;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_busy_d    <= 1'b0;
            r_len       <= 8'd0;
            r_chk       <= 8'd0;
            r_idx       <= '0;
            r_to_cnt    <= '0;
            r_rec_en    <= 1'b0;
            r_pkt_data  <= 8'd0;
            r_pkt_valid <= 1'b0;
            r_pkt_last  <= 1'b0;
            r_pkt_len   <= 8'd0;
            r_err_len   <= 1'b0;
            r_err_chk   <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            r_busy_d  <= rec_busy;
            r_err_len <= 1'b0;
            r_err_chk <= 1'b0;
            r_err_to  <= 1'b0;
            r_rec_en  <= ctrl_en;

            case (r_state)
                S_IDLE: begin
                    r_to_cnt <= '0;
                    if (ctrl_en && w_byte_stb && (rec_dout == HEADER)) begin
                        r_chk   <= 8'd0;
                        r_state <= S_LEN;
                    end
                end

                S_LEN, S_DATA, S_CHK: begin
                    if (!ctrl_en) begin
                        // Disable mid-packet is a deliberate abort, not an error.
                        r_state <= S_IDLE;
                    end else if (w_byte_stb) begin
                        // A strobe in the terminal-count cycle still wins.
                        r_to_cnt <= '0;
                        if (r_state == S_LEN) begin
                            if (w_len_ok) begin
                                r_len   <= rec_dout;
                                r_chk   <= rec_dout;
                                r_idx   <= '0;
                                r_state <= S_DATA;
                            end else begin
                                r_err_len <= 1'b1;
                                r_state   <= S_IDLE;
                            end
                        end else if (r_state == S_DATA) begin
                            r_chk <= r_chk ^ rec_dout;
                            r_idx <= w_idx_inc;
                            if (w_idx_final) begin
                                r_state <= S_CHK;
                            end
                        end else begin
                            if (rec_dout == r_chk) begin
                                r_idx       <= '0;
                                r_pkt_len   <= r_len;
                                r_pkt_valid <= 1'b1;
                                r_pkt_data  <= r_buf[0];
                                r_pkt_last  <= (r_len == 8'd1);
                                r_rec_en    <= 1'b0;
                                r_state     <= S_SEND;
                            end else begin
                                r_err_chk <= 1'b1;
                                r_state   <= S_IDLE;
                            end
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_err_to <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                S_SEND: begin
                    r_rec_en <= 1'b0;
                    if (r_pkt_valid && pkt_ready) begin
                        if (r_pkt_last) begin
                            r_pkt_valid <= 1'b0;
                            r_pkt_last  <= 1'b0;
                            r_pkt_data  <= 8'd0;
                            r_pkt_len   <= 8'd0;
                            r_rec_en    <= ctrl_en;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx      <= w_idx_inc;
                            r_pkt_data <= r_buf[w_idx_inc[BUF_AW-1:0]];
                            r_pkt_last <= (8'(w_idx_inc) == (r_len - 8'd1));
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rec_en    = r_rec_en;
    assign pkt_data  = r_pkt_data;
    assign pkt_valid = r_pkt_valid;
    assign pkt_last  = r_pkt_last;
    assign pkt_len   = r_pkt_len;
    assign err_len   = r_err_len;
    assign err_chk   = r_err_chk;
    assign err_to    = r_err_to;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_pkt_ctrl
// Directed bench for uart_rx_pkt_ctrl. Bytes are delivered the way uart_recv
// does it: rec_dout set, rec_busy high for a few cycles, then low. A negedge
// monitor collects transferred payload bytes and counts error pulses so the
// directed steps can compare against hand-computed values.
// The inter-byte timeout is shortened to keep the run small.
// ---------------------------------------------------------------------------
module tb_uart_rx_pkt_ctrl;

    localparam int T = 100;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       ctrl_en;
    logic [7:0] rec_dout;
    logic       rec_busy;
    logic       rec_en;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic [7:0] pkt_len;
    logic       err_len;
    logic       err_chk;
    logic       err_to;

    uart_rx_pkt_ctrl #(
        .HEADER      (8'hA5),
        .MAX_LEN     (16),
        .TIMEOUT_CYC (T)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ctrl_en   (ctrl_en),
        .rec_dout  (rec_dout),
        .rec_busy  (rec_busy),
        .rec_en    (rec_en),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_last  (pkt_last),
        .pkt_len   (pkt_len),
        .err_len   (err_len),
        .err_chk   (err_chk),
        .err_to    (err_to)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [7:0] q_data [$];
    bit         q_last [$];
    logic [7:0] q_len  [$];
    int         q_cyc  [$];
    int n_valid = 0, n_stall = 0, n_hold_bad = 0, n_recen_bad = 0;
    int n_elen = 0, n_echk = 0, n_eto = 0, n_multi = 0;
    logic       hold_chk = 1'b0;
    logic [7:0] held = 8'd0;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (pkt_valid && pkt_ready) begin
                q_data.push_back(pkt_data);
                q_last.push_back(pkt_last);
                q_len.push_back(pkt_len);
                q_cyc.push_back(cyc);
            end
            if (pkt_valid) n_valid <= n_valid + 1;
            if (pkt_valid && !pkt_ready) n_stall <= n_stall + 1;
            if (pkt_valid && rec_en) n_recen_bad <= n_recen_bad + 1;
            if (hold_chk && pkt_valid && (pkt_data !== held)) n_hold_bad <= n_hold_bad + 1;
            hold_chk <= pkt_valid && !pkt_ready;
            held     <= pkt_data;
            if (err_len) n_elen <= n_elen + 1;
            if (err_chk) n_echk <= n_echk + 1;
            if (err_to)  n_eto  <= n_eto + 1;
            if ((32'(err_len) + 32'(err_chk) + 32'(err_to)) > 32'd1) n_multi <= n_multi + 1;
        end else begin
            hold_chk <= 1'b0;
        end
    end

    function automatic int errs();
        return n_elen + n_echk + n_eto;
    endfunction

    // ---------------- checking / stimulus helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] seq [$];
    int base;
    int e0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns on the clock edge that samples the byte strobe.
    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk);
        #1;
        rec_dout = b;
        rec_busy = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        rec_busy = 1'b0;
        @(posedge sys_clk);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic wait_out(input int n, input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            #1;
            if ((q_data.size() >= base + n) && !pkt_valid) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 32'h1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int st0, c0, v0, l0, t0;
        int bad;
        logic done;

        sys_rst_n = 1'b0;
        ctrl_en   = 1'b0;
        rec_busy  = 1'b0;
        rec_dout  = 8'd0;
        pkt_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_flags", 32'({rec_en, pkt_valid, pkt_last, err_len, err_chk, err_to}), 32'h0);
        check("rst_data", 32'(pkt_data), 32'h0);
        check("rst_len", 32'(pkt_len), 32'h0);
        sys_rst_n = 1'b1;
        ctrl_en   = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rec_en_on", 32'(rec_en), 32'h1);

        // Good packet, downstream always ready
        base = q_data.size(); e0 = errs();
        pkt_ready = 1'b1;
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_seq();
        #1;
        check("t1_valid", 32'(pkt_valid), 32'h1);
        check("t1_first", 32'(pkt_data), 32'h11);
        check("t1_pkt_len", 32'(pkt_len), 32'h3);
        check("t1_rec_en_send", 32'(rec_en), 32'h0);
        wait_out(3, "t1_done");
        check("t1_data", 32'({q_data[base], q_data[base+1], q_data[base+2]}), 32'h112233);
        check("t1_last", 32'({q_last[base], q_last[base+1], q_last[base+2]}), 32'h1);
        check("t1_consec", 32'(q_cyc[base+2] - q_cyc[base]), 32'h2);
        check("t1_errs", 32'(errs() - e0), 32'h0);
        check("t1_rec_en_back", 32'(rec_en), 32'h1);

        // Same packet under alternating backpressure
        base = q_data.size(); st0 = n_stall;
        pkt_ready = 1'b0;
        send_seq();
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge sys_clk);
            #1;
            pkt_ready = ~pkt_ready;
            @(negedge sys_clk);
            #1;
            if ((q_data.size() >= base + 3) && !pkt_valid) begin
                done = 1'b1;
                break;
            end
        end
        pkt_ready = 1'b1;
        check("t2_done", 32'(done), 32'h1);
        check("t2_data", 32'({q_data[base], q_data[base+1], q_data[base+2]}), 32'h112233);
        check("t2_last", 32'({q_last[base], q_last[base+1], q_last[base+2]}), 32'h1);
        check("t2_stalls", 32'(n_stall - st0), 32'h3);
        check("t2_hold", 32'(n_hold_bad), 32'h0);

        // Checksum mismatch, then a good packet
        base = q_data.size(); e0 = errs(); c0 = n_echk; v0 = n_valid;
        seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        send_seq();
        #1;
        check("t3_echk_pulse", 32'(err_chk), 32'h1);
        @(posedge sys_clk);
        #1;
        check("t3_echk_width", 32'(err_chk), 32'h0);
        check("t3_echk_cnt", 32'(n_echk - c0), 32'h1);
        check("t3_errs", 32'(errs() - e0), 32'h1);
        check("t3_novalid", 32'(n_valid - v0), 32'h0);
        seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        send_seq();
        wait_out(2, "t3b_done");
        check("t3b_data", 32'({q_data[base], q_data[base+1]}), 32'h1020);
        check("t3b_last", 32'({q_last[base], q_last[base+1]}), 32'h1);

        // Length errors
        base = q_data.size(); e0 = errs(); l0 = n_elen;
        seq = '{8'hA5, 8'h00};
        send_seq();
        #1;
        check("t4_len0", 32'(err_len), 32'h1);
        seq = '{8'hA5, 8'h11};
        send_seq();
        #1;
        check("t4_len17", 32'(err_len), 32'h1);
        @(negedge sys_clk);
        #1;
        check("t4_elen_cnt", 32'(n_elen - l0), 32'h2);
        check("t4_errs", 32'(errs() - e0), 32'h2);
        check("t4_noout", 32'(q_data.size() - base), 32'h0);

        // Maximum length payload 00..0F; XOR of 00..0F is 0 so checksum = 10
        base = q_data.size(); e0 = errs();
        seq.delete();
        seq.push_back(8'hA5);
        seq.push_back(8'h10);
        for (int i = 0; i < 16; i++) seq.push_back(8'(i));
        seq.push_back(8'h10);
        send_seq();
        wait_out(16, "t4_max_done");
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if ((q_data[base+i] !== 8'(i)) || (q_last[base+i] !== (i == 15))) bad++;
        end
        check("t4_max_payload", 32'(bad), 32'h0);
        check("t4_max_len", 32'(q_len[base]), 32'h10);

        // Leading junk ignored, single byte packet
        base = q_data.size();
        seq = '{8'h5A, 8'h00, 8'hA5, 8'h01, 8'h77, 8'h76};
        send_seq();
        wait_out(1, "t4_junk_done");
        check("t4_junk_data", 32'(q_data[base]), 32'h77);
        check("t4_junk_last", 32'(q_last[base]), 32'h1);
        check("t4_junk_len", 32'(q_len[base]), 32'h1);
        check("t4_junk_errs", 32'(errs() - e0), 32'h0);

        // Inter-byte timeout
        base = q_data.size(); e0 = errs(); t0 = n_eto;
        seq = '{8'hA5, 8'h02, 8'h44};
        send_seq();
        n = 0;
        for (int i = 0; i < 3 * T; i++) begin
            @(posedge sys_clk);
            n++;
            #1;
            if (err_to) break;
        end
        check("t5_to_latency", 32'(n), 32'(T - 1));
        @(negedge sys_clk);
        #1;
        check("t5_eto_cnt", 32'(n_eto - t0), 32'h1);
        send_byte(8'h55);
        repeat (4) @(posedge sys_clk);
        #1;
        check("t5_noout", 32'(q_data.size() - base), 32'h0);
        check("t5_errs", 32'(errs() - e0), 32'h1);

        // Strobe landing in the terminal-count cycle beats the timeout
        base = q_data.size(); e0 = errs();
        send_byte(8'hA5);
        repeat (T - 4) @(posedge sys_clk);
        #1;
        rec_dout = 8'h01;
        rec_busy = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        rec_busy = 1'b0;
        @(posedge sys_clk);
        #1;
        check("t5_stb_wins", 32'(err_to), 32'h0);
        seq = '{8'h5A, 8'h5B};
        send_seq();
        wait_out(1, "t5b_done");
        check("t5b_data", 32'(q_data[base]), 32'h5A);
        check("t5b_errs", 32'(errs() - e0), 32'h0);

        // Silent abort by ctrl_en
        base = q_data.size(); e0 = errs();
        seq = '{8'hA5, 8'h02};
        send_seq();
        #1;
        ctrl_en = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("t6_rec_en_off", 32'(rec_en), 32'h0);
        ctrl_en = 1'b1;
        seq = '{8'hA5, 8'h01, 8'h99, 8'h98};
        send_seq();
        wait_out(1, "t6_done");
        check("t6_data", 32'(q_data[base]), 32'h99);
        check("t6_errs", 32'(errs() - e0), 32'h0);

        // Async reset during SEND
        pkt_ready = 1'b0;
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_seq();
        #1;
        check("t7_in_send", 32'(pkt_valid), 32'h1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("t7_rst_flags", 32'({rec_en, pkt_valid, pkt_last, err_len, err_chk, err_to}), 32'h0);
        check("t7_rst_data", 32'(pkt_data), 32'h0);
        check("t7_rst_len", 32'(pkt_len), 32'h0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        pkt_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("t7_post_valid", 32'(pkt_valid), 32'h0);
        check("t7_post_rec_en", 32'(rec_en), 32'h1);

        // Global properties
        check("recen_in_send", 32'(n_recen_bad), 32'h0);
        check("hold_stable", 32'(n_hold_bad), 32'h0);
        check("err_exclusive", 32'(n_multi), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
